mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-master arbiter for the tiny32 memory bus. It shares one slave port (ROM/RAM/ports decode plus backing memories) between the CPU (master 0) and a second requester such as a DMA engine (master 1). It grants the bus one transaction at a time, using round-robin or fixed priority. A bounded-wait watchdog returns an error instead of hanging when the slave never asserts ready. It sits between the masters and the existing address decode, on the same clock that drives the memory strobes.

## Interface
Parameters:
- FIXED_PRIORITY, 0, 0 = round-robin; 1 = master 0 always wins simultaneous requests
- TIMEOUT_BITS, 8, width of watchdog counter; timeout after 2^TIMEOUT_BITS BUSY cycles

Ports:
- clk  in  1  single clock, all state on posedge
- nreset  in  1  synchronous, active-low reset
- m0_valid, m1_valid  in  1  request; held high with request fields stable until own ready
- m0_nwr, m1_nwr  in  4  per-byte write enables, active low; 4'hF = read
- m0_address, m1_address  in  32  byte address
- m0_wdata, m1_wdata  in  32  write data
- m0_rdata, m1_rdata  out  32  read data, valid while own ready=1
- m0_ready, m1_ready  out  1  one-cycle completion pulse
- m0_error, m1_error  out  1  qualifies ready: 1 = watchdog timeout
- mem_valid  out  1  slave request
- mem_nwr  out  4  slave byte write enables, active low
- address  out  32  slave address
- data_out  out  32  slave write data
- mem_rdata  in  32  slave read data
- mem_ready  in  1  slave completion
- grant  out  2  one-hot current owner; 2'b00 when idle

## Operation
- All outputs are registered.
- States:
  - IDLE: no owner, mem_valid=0. On any valid, select a winner, capture its nwr/address/wdata into the slave registers, set grant, clear the watchdog, go to BUSY.
  - BUSY: mem_valid=1 with the captured fields. Watchdog increments each cycle.
    - If mem_ready=1: latch mem_rdata into the owner's rdata, go to ACK with error=0.
    - Else if watchdog is all-ones: rdata=0, go to ACK with error=1.
  - ACK: owner's ready=1 (error as set), mem_valid=0, mem_nwr=4'hF. The owner's valid is ignored this cycle. Next state is IDLE with grant=00.
- Winner selection:
  - Only one request present: that master wins.
  - Both present, FIXED_PRIORITY=1: m0 wins.
  - Both present, FIXED_PRIORITY=0: the master not recorded in last_grant wins. last_grant updates on each grant.
- mem_ready arriving in the same cycle as the watchdog expiring: ready wins, error=0.
- A master that drops valid while it owns the bus is a protocol violation. The transaction still completes and is acknowledged.
- The non-owner's ready, error and rdata stay 0 throughout.

## Timing
- Reset (nreset=0 at posedge) values:
  - state IDLE, grant=00, mem_valid=0, mem_nwr=4'hF, address=0, data_out=0
  - all m*_ready/m*_error/m*_rdata = 0
  - last_grant=m1, so m0 wins the first tie
  - watchdog=0
- Reset mid-transaction abandons the slave access without a ready pulse.
- Latency:
  - Request sampled at edge N → mem_valid high after N.
  - Slave ready sampled at edge N+k (k≥1) → master ready high after N+k.
  - Back in IDLE after N+k+1. Earliest re-grant is at edge N+k+2.
- Minimum 3 cycles per transaction. Back-to-back requests from both masters alternate under round-robin.
- Timeout: with mem_ready stuck low, ready+error pulse after 2^TIMEOUT_BITS BUSY cycles. Watchdog wraps are never observed.
- Slave-side fields are constant for the whole BUSY interval.

## Test plan
- Reset, then m0 read of 0x00000010, slave ready 1 cycle later with rdata 0xDEADBEEF → mem_valid for 1 cycle, m0_rdata=0xDEADBEEF, m0_ready for exactly 1 cycle, m0_error=0, m1 outputs 0.
- m0 and m1 request in the same cycle repeatedly, FIXED_PRIORITY=0 → grant sequence m0,m1,m0,m1. With FIXED_PRIORITY=1 → m0 always wins until m0 drops valid.
- m1 write nwr=4'b1100, address 0x40000004, wdata 0x12345678 → slave sees exactly those fields, stable throughout BUSY.
- mem_ready held low, TIMEOUT_BITS=4 → m0_ready and m0_error high together after 16 BUSY cycles, m0_rdata=0; the next request is served normally.
- mem_ready asserted in the watchdog's final cycle → ready with error=0 and the slave data.
- nreset pulsed low during BUSY → next cycle mem_valid=0, grant=00, no ready pulse; the subsequent tie grants m0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-master arbiter for the tiny32 memory bus: one transaction at a time,
// round-robin or fixed priority, with a watchdog that turns a stuck slave into an error.
module mem_arbiter #(
    parameter int FIXED_PRIORITY = 0,
    parameter int TIMEOUT_BITS   = 8
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        m0_valid,
    input  logic [3:0]  m0_nwr,
    input  logic [31:0] m0_address,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    output logic        m0_ready,
    output logic        m0_error,
    input  logic        m1_valid,
    input  logic [3:0]  m1_nwr,
    input  logic [31:0] m1_address,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        m1_ready,
    output logic        m1_error,
    output logic        mem_valid,
    output logic [3:0]  mem_nwr,
    output logic [31:0] address,
    output logic [31:0] data_out,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [1:0]  grant,
    output logic [1:0]  fsm_state
);

    // Handshake: a master holds valid with stable fields until its one-cycle ready
    // pulse; error qualifies that pulse (1 = slave never answered, rdata forced 0).
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t                  state;
    logic [TIMEOUT_BITS-1:0] watchdog;
    logic                    last_grant;  // 1 = m1 was granted most recently
    logic                    pick_m1;

    always_comb begin
        pick_m1 = m1_valid;
        if (m0_valid && m1_valid)
            pick_m1 = (FIXED_PRIORITY != 0) ? 1'b0 : ~last_grant;
    end

    assign fsm_state = state;

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state      <= IDLE;
            watchdog   <= '0;
            last_grant <= 1'b1;
            grant      <= 2'b00;
            mem_valid  <= 1'b0;
            mem_nwr    <= 4'hF;
            address    <= '0;
            data_out   <= '0;
            m0_ready   <= 1'b0;
            m0_error   <= 1'b0;
            m0_rdata   <= '0;
            m1_ready   <= 1'b0;
            m1_error   <= 1'b0;
            m1_rdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_valid || m1_valid) begin
                        state      <= BUSY;
                        grant      <= pick_m1 ? 2'b10 : 2'b01;
                        last_grant <= pick_m1;
                        mem_valid  <= 1'b1;
                        mem_nwr    <= pick_m1 ? m1_nwr     : m0_nwr;
                        address    <= pick_m1 ? m1_address : m0_address;
                        data_out   <= pick_m1 ? m1_wdata   : m0_wdata;
                        watchdog   <= '0;
                    end
                end
                BUSY: begin
                    watchdog <= watchdog + TIMEOUT_BITS'(1);
                    // A slave answer in the watchdog's last cycle still counts as success.
                    if (mem_ready || (&watchdog)) begin
                        state     <= ACK;
                        mem_valid <= 1'b0;
                        mem_nwr   <= 4'hF;
                        if (grant[1]) begin
                            m1_ready <= 1'b1;
                            m1_error <= ~mem_ready;
                            m1_rdata <= mem_ready ? mem_rdata : 32'h0;
                        end else begin
                            m0_ready <= 1'b1;
                            m0_error <= ~mem_ready;
                            m0_rdata <= mem_ready ? mem_rdata : 32'h0;
                        end
                    end
                end
                ACK: begin
                    state    <= IDLE;
                    grant    <= 2'b00;
                    m0_ready <= 1'b0;
                    m0_error <= 1'b0;
                    m0_rdata <= '0;
                    m1_ready <= 1'b0;
                    m1_error <= 1'b0;
                    m1_rdata <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed cases plus randomized traffic checked against a
// transaction-level model of winner selection, latency, timeout and slave fields.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        nreset;
    logic        m0_valid, m1_valid;
    logic [3:0]  m0_nwr, m1_nwr;
    logic [31:0] m0_address, m1_address, m0_wdata, m1_wdata;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_ready, m1_ready, m0_error, m1_error;
    logic        mem_valid;
    logic [3:0]  mem_nwr;
    logic [31:0] address, data_out;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic [1:0]  grant, fsm_state;

    logic        f_m0_valid, f_m1_valid;
    logic [31:0] f_m0_rdata, f_m1_rdata;
    logic        f_m0_ready, f_m1_ready, f_m0_error, f_m1_error;
    logic        f_mem_valid;
    logic [3:0]  f_mem_nwr;
    logic [31:0] f_address, f_data_out;
    logic [1:0]  f_grant, f_fsm_state;

    mem_arbiter #(.FIXED_PRIORITY(0), .TIMEOUT_BITS(4)) u_rr (
        .clk(clk), .nreset(nreset),
        .m0_valid(m0_valid), .m0_nwr(m0_nwr), .m0_address(m0_address), .m0_wdata(m0_wdata),
        .m0_rdata(m0_rdata), .m0_ready(m0_ready), .m0_error(m0_error),
        .m1_valid(m1_valid), .m1_nwr(m1_nwr), .m1_address(m1_address), .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata), .m1_ready(m1_ready), .m1_error(m1_error),
        .mem_valid(mem_valid), .mem_nwr(mem_nwr), .address(address), .data_out(data_out),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .grant(grant), .fsm_state(fsm_state)
    );

    mem_arbiter #(.FIXED_PRIORITY(1), .TIMEOUT_BITS(4)) u_fp (
        .clk(clk), .nreset(nreset),
        .m0_valid(f_m0_valid), .m0_nwr(4'hF), .m0_address(32'h100), .m0_wdata(32'h0),
        .m0_rdata(f_m0_rdata), .m0_ready(f_m0_ready), .m0_error(f_m0_error),
        .m1_valid(f_m1_valid), .m1_nwr(4'h0), .m1_address(32'h200), .m1_wdata(32'h1),
        .m1_rdata(f_m1_rdata), .m1_ready(f_m1_ready), .m1_error(f_m1_error),
        .mem_valid(f_mem_valid), .mem_nwr(f_mem_nwr), .address(f_address), .data_out(f_data_out),
        .mem_rdata(32'hA5A5_0000), .mem_ready(1'b1), .grant(f_grant), .fsm_state(f_fsm_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    // model state: requests per master and the most recent grant
    logic        mv[2];
    logic [3:0]  mnwr[2];
    logic [31:0] maddr[2];
    logic [31:0] mwd[2];
    int          last_m;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_masters();
        m0_valid = mv[0]; m0_nwr = mnwr[0]; m0_address = maddr[0]; m0_wdata = mwd[0];
        m1_valid = mv[1]; m1_nwr = mnwr[1]; m1_address = maddr[1]; m1_wdata = mwd[1];
    endtask

    task automatic new_req(input int m, input logic [3:0] nwr, input logic [31:0] a, input logic [31:0] d);
        mv[m] = 1'b1; mnwr[m] = nwr; maddr[m] = a; mwd[m] = d;
    endtask

    function automatic int pick_winner();
        if (mv[0] && mv[1]) return 1 - last_m;
        return mv[1] ? 1 : 0;
    endfunction

    // Called at a negedge with the DUT idle and requests already driven.
    // k = BUSY cycle in which the slave answers; k > 16 means it never does.
    task automatic run_one(input int k, input logic [31:0] rval, input bit drop);
        int          w;
        int          n_busy;
        logic        ee;
        logic [31:0] er;
        w = pick_winner();
        last_m = w;
        ee = (k > 16);
        exp_q.push_back(ee ? 32'h0 : rval);
        n_busy = ee ? 16 : k;
        @(negedge clk);
        check_value("grant", 32'(grant), (w == 1) ? 32'd2 : 32'd1);
        for (int c = 1; c <= n_busy; c++) begin
            if (c > 1) @(negedge clk);
            check_value("busy_valid", 32'(mem_valid), 32'd1);
            check_value("busy_nwr", 32'(mem_nwr), 32'(mnwr[w]));
            check_value("busy_addr", address, maddr[w]);
            check_value("busy_wdata", data_out, mwd[w]);
            check_value("busy_noready", 32'({m0_ready, m1_ready}), 32'd0);
            mem_rdata = $urandom;
            if (c == k) begin
                mem_ready = 1'b1;
                mem_rdata = rval;
            end
            if (drop && c == 1) begin
                mv[w] = 1'b0;
                drive_masters();
            end
        end
        @(negedge clk);
        mem_ready = 1'b0;
        er = exp_q.pop_front();
        check_value("ack_ready", 32'((w == 1) ? m1_ready : m0_ready), 32'd1);
        check_value("ack_error", 32'((w == 1) ? m1_error : m0_error), 32'(ee));
        check_value("ack_rdata", (w == 1) ? m1_rdata : m0_rdata, er);
        check_value("other_quiet", 32'((w == 1) ? {m0_ready, m0_error} : {m1_ready, m1_error}), 32'd0);
        check_value("other_rdata", (w == 1) ? m0_rdata : m1_rdata, 32'h0);
        check_value("ack_slave", 32'({mem_valid, mem_nwr}), 32'h0F);
        mv[w] = 1'b0;
        drive_masters();
        @(negedge clk);
        check_value("idle_grant", 32'(grant), 32'd0);
        check_value("idle_ready", 32'({m0_ready, m1_ready}), 32'd0);
    endtask

    initial begin
        int sel, k, cyc;
        nreset = 1'b0;
        mem_ready = 1'b0; mem_rdata = 32'h0;
        f_m0_valid = 1'b0; f_m1_valid = 1'b0;
        for (int m = 0; m < 2; m++) begin
            mv[m] = 1'b0; mnwr[m] = 4'hF; maddr[m] = 32'h0; mwd[m] = 32'h0;
        end
        drive_masters();
        last_m = 1;
        repeat (3) @(negedge clk);
        check_value("rst_grant", 32'(grant), 32'd0);
        check_value("rst_slave", 32'({mem_valid, mem_nwr}), 32'h0F);
        check_value("rst_addr", address, 32'h0);
        check_value("rst_dout", data_out, 32'h0);
        check_value("rst_m0", 32'({m0_ready, m0_error}), 32'd0);
        check_value("rst_m1", 32'({m1_ready, m1_error}), 32'd0);
        check_value("rst_rdata", m0_rdata | m1_rdata, 32'h0);
        nreset = 1'b1;

        // m0 read, one-cycle slave
        new_req(0, 4'hF, 32'h0000_0010, 32'h0); drive_masters();
        run_one(1, 32'hDEAD_BEEF, 1'b0);
        // m1 byte-lane write
        new_req(1, 4'b1100, 32'h4000_0004, 32'h1234_5678); drive_masters();
        run_one(3, 32'h5555_0000, 1'b0);
        // slave never answers, then normal service
        new_req(0, 4'hF, 32'h0000_0100, 32'h0); drive_masters();
        run_one(99, 32'h0, 1'b0);
        new_req(0, 4'hF, 32'h0000_0104, 32'h0); drive_masters();
        run_one(2, 32'hCAFE_F00D, 1'b0);
        // answer in the watchdog's final cycle
        new_req(1, 4'hF, 32'h0000_0200, 32'h0); drive_masters();
        run_one(16, 32'h0BAD_F00D, 1'b0);
        // persistent ties alternate
        new_req(0, 4'hF, 32'h10, 32'h0); new_req(1, 4'hF, 32'h20, 32'h0); drive_masters();
        for (int t = 0; t < 4; t++) begin
            run_one(1, 32'h1000 + t, 1'b0);
            if (!mv[0]) new_req(0, 4'hF, 32'h10, 32'h0);
            if (!mv[1]) new_req(1, 4'hF, 32'h20, 32'h0);
            drive_masters();
        end
        mv[0] = 1'b0; mv[1] = 1'b0; drive_masters();
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);

        // reset during BUSY, owned by m0 so the tie afterwards proves last_grant reset
        new_req(0, 4'h0, 32'h0000_0300, 32'hFFFF_0000); drive_masters();
        @(negedge clk);
        check_value("pre_rst_grant", 32'(grant), 32'd1);
        @(negedge clk);
        nreset = 1'b0;
        @(negedge clk);
        check_value("mid_rst_valid", 32'(mem_valid), 32'd0);
        check_value("mid_rst_grant", 32'(grant), 32'd0);
        check_value("mid_rst_ready", 32'({m0_ready, m1_ready}), 32'd0);
        check_value("mid_rst_addr", address, 32'h0);
        nreset = 1'b1;
        last_m = 1;
        new_req(1, 4'hF, 32'h0000_0400, 32'h0); drive_masters();
        run_one(2, 32'h7777_8888, 1'b0);
        run_one(1, 32'h9999_AAAA, 1'b0);

        // randomized traffic
        for (int it = 0; it < 50; it++) begin
            for (int m = 0; m < 2; m++)
                if (!mv[m] && $urandom_range(0, 2) != 0)
                    new_req(m, 4'($urandom), $urandom, $urandom);
            if (!mv[0] && !mv[1])
                new_req(int'($urandom_range(0, 1)), 4'($urandom), $urandom, $urandom);
            drive_masters();
            sel = int'($urandom_range(0, 9));
            k = (sel < 6) ? int'($urandom_range(1, 4)) : (sel == 6) ? 15 : (sel == 7) ? 16 : 99;
            run_one(k, $urandom, $urandom_range(0, 7) == 0);
        end

        // fixed priority: m0 keeps winning until it drops valid
        f_m0_valid = 1'b1; f_m1_valid = 1'b1;
        for (int t = 0; t < 4; t++) begin
            cyc = 0;
            do begin @(negedge clk); cyc++; end while (!f_mem_valid && cyc < 8);
            check_value("fp_busy", 32'(f_mem_valid), 32'd1);
            check_value("fp_grant", 32'(f_grant), (t < 3) ? 32'd1 : 32'd2);
            cyc = 0;
            do begin @(negedge clk); cyc++; end while (!(f_m0_ready || f_m1_ready) && cyc < 8);
            check_value("fp_ready", 32'({f_m1_ready, f_m0_ready}), (t < 3) ? 32'd1 : 32'd2);
            check_value("fp_rdata", (t < 3) ? f_m0_rdata : f_m1_rdata, 32'hA5A5_0000);
            if (t == 2) f_m0_valid = 1'b0;
            if (t == 3) f_m1_valid = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
